regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register file's single write port between two writeback requesters:
//    A = ALU / execute result, B = load / long-latency unit.
//  Keeps a per-register pending-write scoreboard so issue logic can detect RAW hazards.
//  Sits between the execute/memory stages and REGFILE; drives its regwrite/write1/write_data.
// PARAMETERS
//  DATA_W   32  writeback data width
//  ADDR_W    5  register address width
//  NREG     32  number of architectural registers
//  PEND_W    2  width of the per-register outstanding-write counter
// PORTS
//  CLK            in   1       clock, rising edge
//  RST            in   1       reset, asynchronous, active-high
//  a_valid        in   1       requester A holds a write
//  a_ready        out  1       A accepted this cycle (valid&&ready = transfer)
//  a_addr         in   ADDR_W  A destination register
//  a_data         in   DATA_W  A write data
//  b_valid/b_ready/b_addr/b_data   same as A, for requester B
//  rsv_valid      in   1       issue stage reserves destination rsv_addr
//  rsv_ready      out  1       reservation accepted
//  rsv_addr       in   ADDR_W  register being reserved
//  chk_addr1      in   ADDR_W  hazard query address, source 1
//  chk_addr2      in   ADDR_W  hazard query address, source 2
//  chk_busy1      out  1       chk_addr1 has a write outstanding
//  chk_busy2      out  1       chk_addr2 has a write outstanding
//  rf_regwrite    out  1       to REGFILE regwrite
//  rf_write1      out  ADDR_W  to REGFILE write1
//  rf_write_data  out  DATA_W  to REGFILE write_data
//  err_unrsv      out  1       sticky: a write was accepted to a register with pending count 0
// BEHAVIOUR
//  Reset (async, RST=1):
//   - all pending counters 0; output stage empty
//   - rf_regwrite=0, rf_write1=0, rf_write_data=0, err_unrsv=0
//   - round-robin pointer = A
//   - a_ready=b_ready=0 while RST is high
//   - reset mid-operation discards any in-flight write; REGFILE contents are untouched
//  Arbitration (combinational grant, registered output):
//   - only one valid -> grant it
//   - both valid -> grant the side the pointer names; pointer flips to the other side after every
//     contended grant; uncontended grants leave the pointer unchanged
//   - ready is asserted only to the granted side; valid must hold with stable addr/data until ready
//  Output stage:
//   - accepted write appears on rf_* the next cycle (latency 1); REGFILE commits at that edge's
//     successor
//   - the stage drains every cycle, so no backpressure from the regfile side
//   - rf_regwrite=1 for exactly one cycle per accepted write
//  Register 0:
//   - writes to addr 0 are accepted (ready asserted) but rf_regwrite stays 0
//   - reservations of addr 0 are accepted and ignored
//   - chk_busy for addr 0 is always 0
//  Scoreboard:
//   - cnt[r] increments on rsv_valid&&rsv_ready; decrements in the cycle rf_regwrite=1 for r
//   - same-cycle increment and decrement on the same r: net no change
//   - rsv_ready=0 when cnt[rsv_addr] is at its max (2^PEND_W-1), unless a decrement of that
//     register commits the same cycle
//   - chk_busyN = (cnt[chk_addrN]!=0); combinational; no bypass from the output stage
//   - accepted write to r with cnt[r]==0 (r!=0): err_unrsv sets and holds until reset; counter
//     stays 0 (no underflow)
// STRUCTURE
//  - Add REG_ADDR_W, REG_NUM and PEND_W constants to defs.v alongside WORDSIZE; use them as
//    parameter defaults.
//  - One sub-module, reg_pend_scoreboard: counter array, inc/dec ports, two query ports,
//    max-count flag.
//  - The arbiter, pointer and output stage stay in the top module.
// TESTING
//  1. Reset then idle -> rf_regwrite=0, chk_busy1/2=0, err_unrsv=0, ready outputs 0 during RST.
//  2. rsv x5; A writes x5=0xDEADBEEF
//     -> a_ready same cycle; next cycle rf_regwrite=1, rf_write1=5, data 0xDEADBEEF;
//        chk_busy(5) 1 before, 0 after.
//  3. A and B both valid for 4 cycles (distinct reserved regs)
//     -> grants alternate A,B,A,B; each side's data appears once, in order.
//  4. Reserve x7 three times -> 4th rsv_ready=0; three writes to x7 -> busy until the third commits.
//  5. A writes x0=0x1234 -> a_ready=1, rf_regwrite stays 0, err_unrsv stays 0.
//  6. B writes unreserved x9 -> err_unrsv=1 and sticky; RST asserted mid-transfer
//     -> rf_regwrite=0 immediately, all counters 0.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and helpers for the register-file write arbiter slice.
//   WORDSIZE    : datapath word width (writeback data)
//   REG_ADDR_W  : architectural register address width
//   REG_NUM     : number of architectural registers
//   REG_PEND_W  : width of each per-register outstanding-write counter
//   RR_A / RR_B : round-robin pointer encodings
//   rr_flip     : pointer value naming the other requester
//   pend_max    : saturation value of a PEND_W-bit counter
package regfile_write_arbiter_pkg;

  localparam int unsigned WORDSIZE   = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_NUM    = 32;
  localparam int unsigned REG_PEND_W = 2;

  // Round-robin pointer encodings (which requester wins the next contended cycle).
  localparam logic [0:0] RR_A = 1'b0;
  localparam logic [0:0] RR_B = 1'b1;

  function automatic logic [0:0] rr_flip(input logic [0:0] side);
    return (side == RR_A) ? RR_B : RR_A;
  endfunction

  function automatic int unsigned pend_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/reg_pend_scoreboard.sv
// Per-register outstanding-write counters used for RAW hazard detection.
//   CLK, RST          : clock, async active-high reset (all counters cleared)
//   inc_en/inc_addr   : a reservation of inc_addr is accepted this cycle
//   dec_en/dec_addr   : a write to dec_addr commits this cycle
//   q_addr1/2         : hazard query addresses
//   q_busy1/2         : query register has a write outstanding (combinational)
//   inc_at_max        : counter for inc_addr is saturated
//   dec_underflow     : committing write found no outstanding reservation
// Register 0 never counts and always reads idle.
module reg_pend_scoreboard
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned NREG   = REG_NUM,
  parameter int unsigned PEND_W = REG_PEND_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              inc_en,
  input  logic [ADDR_W-1:0] inc_addr,
  input  logic              dec_en,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic [ADDR_W-1:0] q_addr1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              q_busy1,
  output logic              q_busy2,
  output logic              inc_at_max,
  output logic              dec_underflow
);

  localparam int unsigned       NSLOT    = 1 << ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX  = PEND_W'(pend_max(PEND_W));
  localparam logic [ADDR_W:0]   NREG_LIM = (ADDR_W+1)'(NREG);

  logic [PEND_W-1:0] cnt     [NSLOT];
  logic [PEND_W-1:0] cnt_nxt [NSLOT];
  logic              inc_ok;
  logic              dec_ok;

  // Register 0 and addresses beyond the implemented file never track writes.
  always_comb begin
    inc_ok = inc_en && (inc_addr != '0) && ({1'b0, inc_addr} < NREG_LIM);
    dec_ok = dec_en && (dec_addr != '0) && ({1'b0, dec_addr} < NREG_LIM);
  end

  // Next count: a same-cycle increment and decrement cancel; never wrap either way.
  always_comb begin
    for (int r = 0; r < NSLOT; r++) begin
      cnt_nxt[r] = cnt[r];
      if (inc_ok && (inc_addr == ADDR_W'(r))) begin
        if (!(dec_ok && (dec_addr == ADDR_W'(r))) && (cnt[r] != CNT_MAX)) begin
          cnt_nxt[r] = cnt[r] + PEND_W'(1);
        end
      end else if (dec_ok && (dec_addr == ADDR_W'(r)) && (cnt[r] != '0)) begin
        cnt_nxt[r] = cnt[r] - PEND_W'(1);
      end
    end
  end

  // Counter array.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NSLOT; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NSLOT; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
    end
  end

  // Queries and flags read the registered counts only (no bypass).
  always_comb begin
    q_busy1       = (q_addr1 != '0) && (cnt[q_addr1] != '0);
    q_busy2       = (q_addr2 != '0) && (cnt[q_addr2] != '0);
    inc_at_max    = (cnt[inc_addr] == CNT_MAX);
    dec_underflow = dec_ok && (cnt[dec_addr] == '0) &&
                    !(inc_ok && (inc_addr == dec_addr));
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between requester A (ALU
// result) and requester B (load / long-latency unit), and tracks pending
// writes per register so issue logic can detect RAW hazards.
//   CLK, RST                      : clock, async active-high reset
//   a_valid/a_ready/a_addr/a_data : requester A writeback handshake
//   b_valid/b_ready/b_addr/b_data : requester B writeback handshake
//   rsv_valid/rsv_ready/rsv_addr  : issue-stage destination reservation
//   chk_addr1/2, chk_busy1/2      : combinational hazard queries
//   rf_regwrite/rf_write1/rf_write_data : registered REGFILE write port
//   err_unrsv                     : sticky, a write committed with nothing reserved
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = WORDSIZE,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned NREG   = REG_NUM,
  parameter int unsigned PEND_W = REG_PEND_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              rsv_valid,
  output logic              rsv_ready,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              rf_regwrite,
  output logic [ADDR_W-1:0] rf_write1,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              err_unrsv
);

  logic [0:0]        rr_ptr;
  logic              contend;
  logic              grant_a;
  logic              grant_b;
  logic              accept;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              rsv_fire;
  logic              rsv_dec_same;
  logic              sb_inc_at_max;
  logic              sb_underflow;

  // Grant: a lone requester always wins; on contention the pointer decides.
  always_comb begin
    contend = a_valid && b_valid;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!RST) begin
      if (contend) begin
        grant_a = (rr_ptr == RR_A);
        grant_b = (rr_ptr == RR_B);
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
    accept   = grant_a || grant_b;
    acc_addr = grant_b ? b_addr : a_addr;
    acc_data = grant_b ? b_data : a_data;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // A saturated counter can still take a reservation if its write commits now.
  always_comb begin
    rsv_dec_same = rf_regwrite && (rf_write1 == rsv_addr);
    rsv_ready    = !RST && (!sb_inc_at_max || rsv_dec_same);
    rsv_fire     = rsv_valid && rsv_ready;
  end

  // Pointer only moves after a contended grant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr <= RR_A;
    end else if (contend && accept) begin
      rr_ptr <= rr_flip(rr_ptr);
    end
  end

  // Single-entry output stage; drains every cycle. Writes to x0 are swallowed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rf_regwrite   <= 1'b0;
      rf_write1     <= '0;
      rf_write_data <= '0;
      err_unrsv     <= 1'b0;
    end else begin
      rf_regwrite <= accept && (acc_addr != '0);
      if (accept) begin
        rf_write1     <= acc_addr;
        rf_write_data <= acc_data;
      end
      if (sb_underflow) begin
        err_unrsv <= 1'b1;
      end
    end
  end

  // Counts are released by the write actually presented to the register file.
  reg_pend_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG),
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .CLK           (CLK),
    .RST           (RST),
    .inc_en        (rsv_fire),
    .inc_addr      (rsv_addr),
    .dec_en        (rf_regwrite),
    .dec_addr      (rf_write1),
    .q_addr1       (chk_addr1),
    .q_addr2       (chk_addr2),
    .q_busy1       (chk_busy1),
    .q_busy2       (chk_busy2),
    .inc_at_max    (sb_inc_at_max),
    .dec_underflow (sb_underflow)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus a
// randomized run compared against a behavioural model of the arbiter.
module tb_regfile_write_arbiter;

  logic        CLK;
  logic        RST;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        rsv_valid, rsv_ready;
  logic [4:0]  rsv_addr, chk_addr1, chk_addr2;
  logic        chk_busy1, chk_busy2;
  logic        rf_regwrite;
  logic [4:0]  rf_write1;
  logic [31:0] rf_write_data;
  logic        err_unrsv;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_arbiter dut (
    .CLK(CLK), .RST(RST),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rsv_valid(rsv_valid), .rsv_ready(rsv_ready), .rsv_addr(rsv_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .rf_regwrite(rf_regwrite), .rf_write1(rf_write1), .rf_write_data(rf_write_data),
    .err_unrsv(err_unrsv)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; rsv_valid = 0;
    a_addr = '0; b_addr = '0; rsv_addr = '0;
    a_data = '0; b_data = '0;
    chk_addr1 = '0; chk_addr2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 0;
  endtask

  task automatic test_reset();
    RST = 1;
    a_valid = 1; b_valid = 1; a_addr = 5'd3; b_addr = 5'd4; a_data = 32'h11; b_data = 32'h22;
    rsv_valid = 0; rsv_addr = 5'd3; chk_addr1 = 5'd3; chk_addr2 = 5'd4;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready got=%b want=0", a_ready); end
    n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready got=%b want=0", b_ready); end
    n_checks++; if (rf_regwrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite got=%b want=0", rf_regwrite); end
    n_checks++; if (rf_write1 !== 5'd0 || rf_write_data !== 32'd0) begin n_fail++; $display("FAIL reset_rf_port got=%0d/%h want=0/0", rf_write1, rf_write_data); end
    n_checks++; if (err_unrsv !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b want=0", err_unrsv); end
    a_valid = 0; b_valid = 0;
    #1;
    RST = 0;
    tick();
    tick();
    n_checks++; if (rf_regwrite !== 1'b0) begin n_fail++; $display("FAIL idle_regwrite got=%b want=0", rf_regwrite); end
    n_checks++; if (chk_busy1 !== 1'b0 || chk_busy2 !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b%b want=00", chk_busy1, chk_busy2); end
    n_checks++; if (err_unrsv !== 1'b0) begin n_fail++; $display("FAIL idle_err got=%b want=0", err_unrsv); end
  endtask

  task automatic test_single_write();
    do_reset();
    rsv_valid = 1; rsv_addr = 5'd5; chk_addr1 = 5'd5;
    #1;
    n_checks++; if (rsv_ready !== 1'b1) begin n_fail++; $display("FAIL sw_rsv_ready got=%b want=1", rsv_ready); end
    n_checks++; if (chk_busy1 !== 1'b0) begin n_fail++; $display("FAIL sw_busy_pre got=%b want=0", chk_busy1); end
    tick();
    rsv_valid = 0;
    a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (chk_busy1 !== 1'b1) begin n_fail++; $display("FAIL sw_busy_rsv got=%b want=1", chk_busy1); end
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL sw_ready got=%b%b want=10", a_ready, b_ready); end
    tick();
    a_valid = 0;
    n_checks++; if (rf_regwrite !== 1'b1 || rf_write1 !== 5'd5 || rf_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_commit got=%b/%0d/%h want=1/5/deadbeef", rf_regwrite, rf_write1, rf_write_data); end
    n_checks++; if (chk_busy1 !== 1'b1) begin n_fail++; $display("FAIL sw_busy_commit got=%b want=1", chk_busy1); end
    tick();
    n_checks++; if (rf_regwrite !== 1'b0) begin n_fail++; $display("FAIL sw_one_pulse got=%b want=0", rf_regwrite); end
    n_checks++; if (chk_busy1 !== 1'b0) begin n_fail++; $display("FAIL sw_busy_post got=%b want=0", chk_busy1); end
  endtask

  task automatic test_round_robin();
    int ai, bi;
    logic        want_a;
    logic [4:0]  want_addr;
    logic [31:0] want_data;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rsv_valid = 1; rsv_addr = 5'(10 + i);
      tick();
    end
    rsv_valid = 0;
    ai = 0; bi = 0;
    for (int k = 0; k < 6; k++) begin
      a_valid = (ai < 3); a_addr = 5'(10 + 2 * ai); a_data = 32'hA000_0000 + 32'(10 + 2 * ai);
      b_valid = (bi < 3); b_addr = 5'(11 + 2 * bi); b_data = 32'hB000_0000 + 32'(11 + 2 * bi);
      want_a    = ((k % 2) == 0);
      want_addr = 5'(10 + k);
      want_data = (want_a ? 32'hA000_0000 : 32'hB000_0000) + 32'(10 + k);
      #1;
      n_checks++; if (a_ready !== want_a || b_ready !== !want_a) begin n_fail++; $display("FAIL rr_grant_%0d got=%b%b want=%b%b", k, a_ready, b_ready, want_a, !want_a); end
      tick();
      n_checks++; if (rf_regwrite !== 1'b1 || rf_write1 !== want_addr || rf_write_data !== want_data) begin n_fail++; $display("FAIL rr_commit_%0d got=%b/%0d/%h want=1/%0d/%h", k, rf_regwrite, rf_write1, rf_write_data, want_addr, want_data); end
      if (want_a) ai++; else bi++;
    end
    a_valid = 0; b_valid = 0;
    tick();
    n_checks++; if (rf_regwrite !== 1'b0) begin n_fail++; $display("FAIL rr_drain got=%b want=0", rf_regwrite); end
  endtask

  task automatic test_pend_limit();
    do_reset();
    chk_addr1 = 5'd7;
    for (int i = 0; i < 3; i++) begin
      rsv_valid = 1; rsv_addr = 5'd7;
      #1;
      n_checks++; if (rsv_ready !== 1'b1) begin n_fail++; $display("FAIL pl_rsv_%0d got=%b want=1", i, rsv_ready); end
      tick();
    end
    #1;
    n_checks++; if (rsv_ready !== 1'b0) begin n_fail++; $display("FAIL pl_rsv_full got=%b want=0", rsv_ready); end
    n_checks++; if (chk_busy1 !== 1'b1) begin n_fail++; $display("FAIL pl_busy_full got=%b want=1", chk_busy1); end
    tick();
    rsv_valid = 0;
    a_valid = 1; a_addr = 5'd7; a_data = 32'h7001;
    tick();
    // Count is saturated but x7 commits this cycle, so a reservation is accepted.
    rsv_valid = 1; a_data = 32'h7002;
    #1;
    n_checks++; if (rsv_ready !== 1'b1) begin n_fail++; $display("FAIL pl_rsv_with_commit got=%b want=1", rsv_ready); end
    n_checks++; if (rf_regwrite !== 1'b1 || rf_write_data !== 32'h7001) begin n_fail++; $display("FAIL pl_commit1 got=%b/%h want=1/7001", rf_regwrite, rf_write_data); end
    tick();
    rsv_valid = 0; a_data = 32'h7003;
    tick();
    a_data = 32'h7004;
    tick();
    a_valid = 0;
    #1;
    n_checks++; if (rf_regwrite !== 1'b1 || rf_write_data !== 32'h7004) begin n_fail++; $display("FAIL pl_commit4 got=%b/%h want=1/7004", rf_regwrite, rf_write_data); end
    n_checks++; if (chk_busy1 !== 1'b1) begin n_fail++; $display("FAIL pl_busy_last got=%b want=1", chk_busy1); end
    tick();
    n_checks++; if (chk_busy1 !== 1'b0) begin n_fail++; $display("FAIL pl_busy_done got=%b want=0", chk_busy1); end
    n_checks++; if (err_unrsv !== 1'b0) begin n_fail++; $display("FAIL pl_err got=%b want=0", err_unrsv); end
  endtask

  task automatic test_reg_zero();
    do_reset();
    rsv_valid = 1; rsv_addr = 5'd0; chk_addr1 = 5'd0;
    a_valid = 1; a_addr = 5'd0; a_data = 32'h1234;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL z_a_ready got=%b want=1", a_ready); end
    n_checks++; if (rsv_ready !== 1'b1) begin n_fail++; $display("FAIL z_rsv_ready got=%b want=1", rsv_ready); end
    tick();
    rsv_valid = 0; a_valid = 0;
    n_checks++; if (rf_regwrite !== 1'b0) begin n_fail++; $display("FAIL z_regwrite got=%b want=0", rf_regwrite); end
    n_checks++; if (chk_busy1 !== 1'b0) begin n_fail++; $display("FAIL z_busy got=%b want=0", chk_busy1); end
    tick();
    n_checks++; if (err_unrsv !== 1'b0) begin n_fail++; $display("FAIL z_err got=%b want=0", err_unrsv); end
  endtask

  // Behavioural model: pending counts per register, one expected write in flight.
  task automatic test_random();
    int          mcnt [32];
    bit          mptr_b, merr, mout_v, a_hold, b_hold;
    bit          eg_a, eg_b, ers, eb1, eb2;
    logic [4:0]  mout_a, gaddr;
    logic [31:0] mout_d;
    do_reset();
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    mptr_b = 0; merr = 0; mout_v = 0; mout_a = '0; mout_d = '0;
    a_hold = 0; b_hold = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!a_hold) begin a_valid = (($urandom % 3) != 0); a_addr = 5'($urandom % 8); a_data = $urandom; end
      if (!b_hold) begin b_valid = (($urandom % 3) != 0); b_addr = 5'($urandom % 8); b_data = $urandom; end
      rsv_valid = 1'($urandom % 2); rsv_addr = 5'($urandom % 8);
      chk_addr1 = 5'($urandom % 8); chk_addr2 = 5'($urandom % 8);
      if (a_valid && b_valid) begin eg_a = !mptr_b; eg_b = mptr_b; end
      else begin eg_a = a_valid; eg_b = b_valid; end
      ers = (mcnt[rsv_addr] < 3) || (mout_v && mout_a == rsv_addr);
      eb1 = (chk_addr1 != 0) && (mcnt[chk_addr1] != 0);
      eb2 = (chk_addr2 != 0) && (mcnt[chk_addr2] != 0);
      #1;
      n_checks++; if (a_ready !== eg_a || b_ready !== eg_b) begin n_fail++; $display("FAIL rnd_grant c%0d got=%b%b want=%b%b", cyc, a_ready, b_ready, eg_a, eg_b); end
      n_checks++; if (rsv_ready !== ers) begin n_fail++; $display("FAIL rnd_rsv_ready c%0d got=%b want=%b", cyc, rsv_ready, ers); end
      n_checks++; if (chk_busy1 !== eb1 || chk_busy2 !== eb2) begin n_fail++; $display("FAIL rnd_busy c%0d got=%b%b want=%b%b", cyc, chk_busy1, chk_busy2, eb1, eb2); end
      if (rsv_valid && ers && rsv_addr != 0) mcnt[rsv_addr] += 1;
      if (mout_v) begin
        if (mcnt[mout_a] == 0) merr = 1;
        else mcnt[mout_a] -= 1;
      end
      if (eg_a || eg_b) begin
        gaddr  = eg_a ? a_addr : b_addr;
        mout_d = eg_a ? a_data : b_data;
        mout_a = gaddr;
        mout_v = (gaddr != 0);
      end else begin
        mout_v = 0;
      end
      if (a_valid && b_valid) mptr_b = !mptr_b;
      a_hold = a_valid && !eg_a;
      b_hold = b_valid && !eg_b;
      tick();
      n_checks++; if (rf_regwrite !== mout_v) begin n_fail++; $display("FAIL rnd_regwrite c%0d got=%b want=%b", cyc, rf_regwrite, mout_v); end
      if (mout_v) begin
        n_checks++; if (rf_write1 !== mout_a || rf_write_data !== mout_d) begin n_fail++; $display("FAIL rnd_rf c%0d got=%0d/%h want=%0d/%h", cyc, rf_write1, rf_write_data, mout_a, mout_d); end
      end
      n_checks++; if (err_unrsv !== merr) begin n_fail++; $display("FAIL rnd_err c%0d got=%b want=%b", cyc, err_unrsv, merr); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_unreserved_and_reset();
    do_reset();
    b_valid = 1; b_addr = 5'd9; b_data = 32'hCAFEF00D;
    #1;
    n_checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin n_fail++; $display("FAIL ur_ready got=%b%b want=01", a_ready, b_ready); end
    tick();
    b_valid = 0;
    n_checks++; if (rf_regwrite !== 1'b1 || rf_write1 !== 5'd9) begin n_fail++; $display("FAIL ur_commit got=%b/%0d want=1/9", rf_regwrite, rf_write1); end
    tick();
    n_checks++; if (err_unrsv !== 1'b1) begin n_fail++; $display("FAIL ur_err_set got=%b want=1", err_unrsv); end
    tick();
    tick();
    n_checks++; if (err_unrsv !== 1'b1) begin n_fail++; $display("FAIL ur_err_sticky got=%b want=1", err_unrsv); end
    rsv_valid = 1; rsv_addr = 5'd3; chk_addr1 = 5'd3;
    tick();
    tick();
    rsv_valid = 0;
    b_valid = 1; b_addr = 5'd3; b_data = 32'h33;
    tick();
    b_valid = 0;
    n_checks++; if (rf_regwrite !== 1'b1 || chk_busy1 !== 1'b1) begin n_fail++; $display("FAIL ur_inflight got=%b%b want=11", rf_regwrite, chk_busy1); end
    #2;
    RST = 1;
    a_valid = 1; b_valid = 1;
    #1;
    n_checks++; if (rf_regwrite !== 1'b0) begin n_fail++; $display("FAIL ur_rst_regwrite got=%b want=0", rf_regwrite); end
    n_checks++; if (err_unrsv !== 1'b0 || chk_busy1 !== 1'b0) begin n_fail++; $display("FAIL ur_rst_state got=%b%b want=00", err_unrsv, chk_busy1); end
    n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_fail++; $display("FAIL ur_rst_ready got=%b%b want=00", a_ready, b_ready); end
    a_valid = 0; b_valid = 0;
    @(posedge CLK);
    #1;
    RST = 0;
    tick();
    n_checks++; if (rf_regwrite !== 1'b0 || chk_busy1 !== 1'b0) begin n_fail++; $display("FAIL ur_post_rst got=%b%b want=00", rf_regwrite, chk_busy1); end
  endtask

  initial begin
    idle_inputs();
    RST = 1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_pend_limit();
    test_reg_zero();
    test_random();
    test_unreserved_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
